// File: rtl/sint_addsub_pipe.sv
// -----------------------------------------------------------------------------
// sint_addsub_pipe
//   Two-stage pipelined two's-complement add/subtract unit with a runtime
//   operation select, valid/ready handshakes on both sides and a signed
//   overflow flag.
//
//   Stage 1 registers the operands and op. Stage 2 registers the result and
//   the overflow flag computed from the stage-1 contents.
//
//   Build option:
//     SINT_ADDSUB_SAT_EN  when defined, overflowing results clamp to the
//                         nearest representable value (ovf still set).
//                         When undefined, results wrap mod 2^WIDTH.
//
// Parameters
//   WIDTH      operand/result width (>= 2)
//
// Ports
//   CLK        clock, rising edge
//   RESET      synchronous reset, active-high
//   I0         operand A (signed)
//   I1         operand B (signed), ignored for NEG
//   op         00 ADD A+B | 01 SUB A-B | 10 RSUB B-A | 11 NEG -A
//   in_valid   I0/I1/op valid
//   in_ready   unit can accept input this cycle
//   O          result (signed)
//   ovf        signed overflow of the result in O
//   out_valid  O/ovf valid
//   out_ready  downstream accepts O this cycle
// -----------------------------------------------------------------------------
module sint_addsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic signed [WIDTH-1:0] I0,
  input  logic signed [WIDTH-1:0] I1,
  input  logic        [1:0]       op,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] O,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_RSUB = 2'b10;

  // One guard bit above the operand width makes every result exact, so
  // overflow is simply a disagreement between the top two bits.
  function automatic logic signed [WIDTH:0] arith(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic        [1:0]       sel
  );
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    logic signed [WIDTH:0] r;
    ea = {a[WIDTH-1], a};
    eb = {b[WIDTH-1], b};
    case (sel)
      OP_ADD:  r = ea + eb;
      OP_SUB:  r = ea - eb;
      OP_RSUB: r = eb - ea;
      default: r = -ea;
    endcase
    return r;
  endfunction

  function automatic logic ovf_of(input logic signed [WIDTH:0] r);
    return r[WIDTH] ^ r[WIDTH-1];
  endfunction

`ifdef SINT_ADDSUB_SAT_EN
  // The guard bit carries the true sign of an overflowed result.
  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [WIDTH:0] r);
    logic signed [WIDTH-1:0] res;
    if (ovf_of(r)) begin
      res = r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = r[WIDTH-1:0];
    end
    return res;
  endfunction
`else
  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [WIDTH:0] r);
    return r[WIDTH-1:0];
  endfunction
`endif

  logic                    vld_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;
  logic        [1:0]       op_p1;
  logic signed [WIDTH:0]   res_p1;

  logic                    vld_p2;
  logic signed [WIDTH-1:0] o_p2;
  logic                    ovf_p2;

  logic adv1;
  logic adv2;
  logic accept;

  assign adv2     = !vld_p2 | out_ready;
  assign adv1     = !vld_p1 | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & in_ready;

  // ---- stage 1: operand capture ----
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_p1  <= I0;
      b_p1  <= I1;
      op_p1 <= op;
    end
  end

  assign res_p1 = arith(a_p1, b_p1, op_p1);

  // ---- stage 2: result capture ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      o_p2   <= '0;
      ovf_p2 <= 1'b0;
    end else begin
      if (adv1) begin
        vld_p1 <= in_valid;
      end
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          o_p2   <= narrow(res_p1);
          ovf_p2 <= ovf_of(res_p1);
        end
      end
    end
  end

  assign O         = o_p2;
  assign ovf       = ovf_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_sint_addsub_pipe.sv
module tb_sint_addsub_pipe;

  localparam int W = 3;
`ifdef SINT_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RESET;
  logic signed [W-1:0] I0;
  logic signed [W-1:0] I1;
  logic        [1:0]   op;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] O;
  logic                ovf;
  logic                out_valid;
  logic                out_ready;

  sint_addsub_pipe #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .O(O), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W:0] exp;
    int         cyc;
    bit         lat;
  } sb_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] ow;
    logic [W-1:0] os;
    logic         v;
  } vec_t;

  sb_t  q[$];
  vec_t tbl[13];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accepted = 0;
  int   delivered = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range check.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] o);
    int sa, sb, r, mx, mn;
    logic [W-1:0] w;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sb - sa;
      default: r = -sa;
    endcase
    mx = (1 << (W - 1)) - 1;
    mn = -(1 << (W - 1));
    v  = (r > mx) || (r < mn);
    w  = r[W-1:0];
    if (SAT && v) w = (r > mx) ? mx[W-1:0] : mn[W-1:0];
    return {v, w};
  endfunction

  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {28'd0, ovf, O}, 32'hFFFF);
      end else begin
        sb_t e;
        e = q.pop_front();
        delivered++;
        chk("result", {28'd0, ovf, O}, {28'd0, e.exp});
        if (e.lat) chk("latency", cyc - e.cyc, 2);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                      input logic [W:0] exp, input bit lat);
    int n;
    n = 0;
    I0 = a; I1 = b; op = o; in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      q.push_back('{exp, cyc, lat});
      accepted++;
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("drain_left", q.size(), 0);
    q.delete();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n, base, c0, cnt;
    logic [31:0] hold;
    bit done;

    RESET = 1'b1; I0 = '0; I1 = '0; op = '0; in_valid = 1'b0; out_ready = 1'b1;

    //             a       b       op     wrap    sat     ovf
    tbl[0]  = '{3'b011, 3'b001, 2'b00, 3'b100, 3'b011, 1'b1}; // 3+1
    tbl[1]  = '{3'b100, 3'b001, 2'b01, 3'b011, 3'b100, 1'b1}; // -4-1
    tbl[2]  = '{3'b001, 3'b110, 2'b10, 3'b101, 3'b101, 1'b0}; // -2-1
    tbl[3]  = '{3'b100, 3'b000, 2'b11, 3'b100, 3'b011, 1'b1}; // -(-4)
    tbl[4]  = '{3'b010, 3'b011, 2'b11, 3'b110, 3'b110, 1'b0}; // -(2)
    tbl[5]  = '{3'b100, 3'b100, 2'b00, 3'b000, 3'b100, 1'b1}; // -4+-4
    tbl[6]  = '{3'b001, 3'b010, 2'b00, 3'b011, 3'b011, 1'b0}; // 1+2
    tbl[7]  = '{3'b000, 3'b100, 2'b01, 3'b100, 3'b011, 1'b1}; // 0-(-4)
    tbl[8]  = '{3'b100, 3'b011, 2'b10, 3'b111, 3'b011, 1'b1}; // 3-(-4)
    tbl[9]  = '{3'b010, 3'b011, 2'b01, 3'b111, 3'b111, 1'b0}; // 2-3
    tbl[10] = '{3'b111, 3'b111, 2'b00, 3'b110, 3'b110, 1'b0}; // -1+-1
    tbl[11] = '{3'b000, 3'b101, 2'b11, 3'b000, 3'b000, 1'b0}; // -(0)
    tbl[12] = '{3'b111, 3'b010, 2'b11, 3'b001, 3'b001, 1'b0}; // -(-1)

    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_O", O, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Directed table, I1 randomised for NEG
    foreach (tbl[i]) begin
      logic [W-1:0] b;
      b = (tbl[i].op == 2'b11) ? W'($urandom) : tbl[i].b;
      send(tbl[i].a, b, tbl[i].op, {tbl[i].v, SAT ? tbl[i].os : tbl[i].ow}, 1'b0);
    end
    drain();

    // Backpressure: 4 ADDs with output stalled
    out_ready = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) send(W'(i), 3'b001, 2'b00, model(W'(i), 3'b001, 2'b00), 1'b0);
      end
      begin
        n = 0;
        @(negedge CLK);
        while (in_ready && n < 50) begin
          n++;
          @(negedge CLK);
        end
        chk("bp_accepts", accepted - base, 2);
        hold = {28'd0, ovf, O};
        for (int k = 0; k < 5; k++) begin
          chk("bp_out_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold", {28'd0, ovf, O}, hold);
          @(negedge CLK);
        end
        @(posedge CLK);
        #2;
        out_ready = 1'b1;
      end
    join
    base = delivered;
    drain();
    chk("bp_delivered", delivered - base, 2);

    // Full throughput with latency checks
    base = delivered;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      logic [1:0] o;
      a = W'($urandom); b = W'($urandom); o = 2'($urandom);
      send(a, b, o, model(a, b, o), 1'b1);
    end
    chk("tp_cycles", cyc - c0, 16);
    drain();
    chk("tp_delivered", delivered - base, 16);

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [W-1:0] a, b;
          logic [1:0] o;
          a = W'($urandom); b = W'($urandom); o = 2'($urandom);
          send(a, b, o, model(a, b, o), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(3'b011, 3'b011, 2'b00, model(3'b011, 3'b011, 2'b00), 1'b0);
    send(3'b001, 3'b001, 2'b00, model(3'b001, 3'b001, 2'b00), 1'b0);
    @(negedge CLK);
    chk("full_in_ready", in_ready, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1; in_valid = 1'b1; I0 = 3'b010; I1 = 3'b001; op = 2'b00;
    @(posedge CLK);
    #1;
    RESET = 1'b0; in_valid = 1'b0;
    q.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_O", O, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (out_valid) cnt++;
    end
    chk("no_stale_output", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
